// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate_fold_pipe unit.
// Op encoding, gate families and fold FSM states.
package gate_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        FAM_AND,
        FAM_OR,
        FAM_XOR,
        FAM_NONE
    } fam_t;

    typedef enum logic {
        FOLD_IDLE,
        FOLD_ACCUM
    } fold_state_t;

    function automatic logic is_inverting(op_t op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic fam_t base_family(op_t op);
        fam_t f;
        unique case (op)
            OP_AND, OP_NAND: f = FAM_AND;
            OP_OR, OP_NOR:   f = FAM_OR;
            OP_XOR, OP_XNOR: f = FAM_XOR;
            default:         f = FAM_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/gate_fold_pipe_if.sv
// Valid/ready beat interface of gate_fold_pipe.
// slave is the DUT view, master the producer/consumer view.
interface gate_fold_pipe_if
    import gate_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_INPUTS*WIDTH-1:0] in_data;
    logic [OP_WIDTH-1:0]         in_op;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_data;
    logic                        out_last;

    modport slave (
        input  in_valid, in_data, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/gate_bitwise_core.sv
// Combinational multi-lane gate: base result g and final result.
// Reserved ops give zero for both.
module gate_bitwise_core
    import gate_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] lanes,
    input  op_t                         op,
    output logic [WIDTH-1:0]            g,
    output logic [WIDTH-1:0]            res
);
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_xor;

    // Reduce all lanes under each family at once.
    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            r_and = r_and & lanes[i*WIDTH +: WIDTH];
            r_or  = r_or  | lanes[i*WIDTH +: WIDTH];
            r_xor = r_xor ^ lanes[i*WIDTH +: WIDTH];
        end
    end

    // Pick the family and apply output inversion.
    always_comb begin
        g = '0;
        unique case (base_family(op))
            FAM_AND: g = r_and;
            FAM_OR:  g = r_or;
            FAM_XOR: g = r_xor;
            default: g = '0;
        endcase
        res = is_inverting(op) ? ~g : g;
    end
endmodule

// File: rtl/gate_fold_pipe.sv
// Two-stage bubbled gate pipeline with optional burst fold.
// Fold FSM and accumulator exist only with GATE_FOLD_EN defined.
module gate_fold_pipe
    import gate_pkg::*;
#(
    parameter int                    WIDTH        = 4,
    parameter int                    NUM_INPUTS   = 2,
    parameter logic [NUM_INPUTS-1:0] BUBBLES_MASK = '0
) (
    input logic             clk,
    input logic             rst_n,
    gate_fold_pipe_if.slave bus
);
    localparam int LW = NUM_INPUTS * WIDTH;

    logic [LW-1:0]    bubble_vec;
    logic             s1_valid_q, s1_valid_d;
    logic [LW-1:0]    s1_lanes_q, s1_lanes_d;
    op_t              s1_op_q, s1_op_d;
    logic             s1_last_q, s1_last_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             s2_free;
    logic             s1_move;
    logic             in_fire;
    op_t              core_op;
    logic [WIDTH-1:0] core_g;
    logic [WIDTH-1:0] core_res;

`ifdef GATE_FOLD_EN
    fold_state_t      state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    op_t              acc_op_q, acc_op_d;
    logic [WIDTH-1:0] acc_fold;
    logic [WIDTH-1:0] fold_res;

    // Later beats of a burst reuse the op latched on the first.
    assign core_op = (state_q == FOLD_ACCUM) ? acc_op_q : s1_op_q;
`else
    assign core_op = s1_op_q;
`endif

    // Spread each lane's bubble bit across the lane width.
    always_comb begin
        bubble_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bubble_vec[i*WIDTH +: WIDTH] = {WIDTH{BUBBLES_MASK[i]}};
        end
    end

    assign s2_free      = ~out_valid_q | bus.out_ready;
    assign s1_move      = s1_valid_q & s2_free;
    assign bus.in_ready = rst_n & (~s1_valid_q | s2_free);
    assign in_fire      = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    gate_bitwise_core #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS)
    ) u_core (
        .lanes (s1_lanes_q),
        .op    (core_op),
        .g     (core_g),
        .res   (core_res)
    );

    // Stage 1: capture bubbled lanes, op and last.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lanes_d = s1_lanes_q;
        s1_op_d    = s1_op_q;
        s1_last_d  = s1_last_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_lanes_d = bus.in_data ^ bubble_vec;
            s1_op_d    = op_t'(bus.in_op);
            s1_last_d  = bus.in_last;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

`ifdef GATE_FOLD_EN
    // Fold the new base result into the accumulator.
    always_comb begin
        acc_fold = '0;
        unique case (base_family(acc_op_q))
            FAM_AND: acc_fold = acc_q & core_g;
            FAM_OR:  acc_fold = acc_q | core_g;
            FAM_XOR: acc_fold = acc_q ^ core_g;
            default: acc_fold = '0;
        endcase
        fold_res = is_inverting(acc_op_q) ? ~acc_fold : acc_fold;
    end
`endif

    // Stage 2: output register and fold next-state.
    always_comb begin
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef GATE_FOLD_EN
        state_d  = state_q;
        acc_d    = acc_q;
        acc_op_d = acc_op_q;
        if (s1_move) begin
            unique case (state_q)
                FOLD_IDLE: begin
                    if (s1_last_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = core_res;
                        out_last_d  = 1'b1;
                    end else begin
                        state_d  = FOLD_ACCUM;
                        acc_d    = core_g;
                        acc_op_d = s1_op_q;
                    end
                end
                FOLD_ACCUM: begin
                    if (s1_last_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = fold_res;
                        out_last_d  = 1'b1;
                        state_d     = FOLD_IDLE;
                        acc_d       = '0;
                    end else begin
                        acc_d = acc_fold;
                    end
                end
                default: state_d = FOLD_IDLE;
            endcase
        end
`else
        if (s1_move) begin
            out_valid_d = 1'b1;
            out_data_d  = core_res;
            out_last_d  = s1_last_q;
        end
`endif
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lanes_q  <= '0;
            s1_op_q     <= OP_AND;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lanes_q  <= s1_lanes_d;
            s1_op_q     <= s1_op_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef GATE_FOLD_EN
    // Fold state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FOLD_IDLE;
            acc_q    <= '0;
            acc_op_q <= OP_AND;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            acc_op_q <= acc_op_d;
        end
    end
`endif
endmodule

// File: tb/tb_gate_fold_pipe.sv
// Self-checking bench for gate_fold_pipe.
// Covers fold bursts when built with GATE_FOLD_EN.
module tb_gate_fold_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    logic [3:0] cq_d[$];
    logic       cq_l[$];
    int         cq_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_fold_pipe_if #(.WIDTH(4), .NUM_INPUTS(2)) ifa ();
    gate_fold_pipe_if #(.WIDTH(4), .NUM_INPUTS(2)) ifb ();
    gate_fold_pipe_if #(.WIDTH(4), .NUM_INPUTS(3)) ifc ();

    gate_fold_pipe #(.WIDTH(4), .NUM_INPUTS(2), .BUBBLES_MASK(2'b00)) ua (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    gate_fold_pipe #(.WIDTH(4), .NUM_INPUTS(2), .BUBBLES_MASK(2'b01)) ub (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    gate_fold_pipe #(.WIDTH(4), .NUM_INPUTS(3), .BUBBLES_MASK(3'b000)) uc (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            cq_d.push_back(ifc.out_data);
            cq_l.push_back(ifc.out_last);
            cq_c.push_back(cyc);
        end
    end

    function automatic logic [3:0] model(input logic [11:0] d, input int n,
                                         input logic [2:0] mask, input logic [2:0] op);
        int lane;
        int r;
        if (op > 3'd5) return 4'h0;
        r = (op < 3'd2) ? 15 : 0;
        for (int i = 0; i < n; i++) begin
            lane = int'(d[4*i +: 4]);
            if (mask[i]) lane = 15 - lane;
            if (op < 3'd2) r = r & lane;
            else if (op < 3'd4) r = r | lane;
            else r = r ^ lane;
        end
        if (op[0]) r = 15 - r;
        return r[3:0];
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready got a=%b b=%b want 0", ifa.in_ready, ifb.in_ready);
        end
        tests++;
        if (ifa.out_valid !== 1'b0 || ifa.out_data !== 4'h0 || ifa.out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_out got v=%b d=%h l=%b want 0/0/0",
                     ifa.out_valid, ifa.out_data, ifa.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got %b want 1", ifa.in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'hAC;
        ifa.in_op     = 3'd1;
        ifa.in_last   = 1'b1;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL lat_accept got in_ready=%b want 1", ifa.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        #1;
        tests++;
        if (ifa.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_early got out_valid=%b want 0", ifa.out_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'h7) begin
            fails++;
            $display("FAIL lat_nand got v=%b d=%h want 1/7", ifa.out_valid, ifa.out_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (ifa.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_once got out_valid=%b want 0", ifa.out_valid);
        end
    endtask

    task automatic test_mask();
        logic [7:0] dv[2];
        logic [3:0] ev[2];
        int         w;
        dv[0] = 8'h3F; ev[0] = 4'h0;
        dv[1] = 8'h30; ev[1] = 4'h3;
        ifb.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifb.in_valid = 1'b1;
            ifb.in_data  = dv[k];
            ifb.in_op    = 3'd0;
            ifb.in_last  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ifb.in_valid = 1'b0;
            #1;
            w = 0;
            while (!ifb.out_valid && w < 5) begin
                @(negedge clk);
                #1;
                w++;
            end
            tests++;
            if (ifb.out_valid !== 1'b1 || ifb.out_data !== ev[k]) begin
                fails++;
                $display("FAIL mask_and%0d got v=%b d=%h want 1/%h",
                         k, ifb.out_valid, ifb.out_data, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reserved();
        int         n = 0;
        logic [3:0] seen = 4'hF;
        @(negedge clk);
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'($urandom);
        ifa.in_op     = 3'd6;
        ifa.in_last   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ifa.out_valid) begin
                n++;
                seen = ifa.out_data;
            end
            @(negedge clk);
        end
        tests++;
        if (n != 1 || seen !== 4'h0) begin
            fails++;
            $display("FAIL reserved got count=%0d d=%h want 1/0", n, seen);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] eq[$];
        logic [3:0] e;
        int         acc_n = 0;
        logic [7:0] d;
        logic [2:0] op;
        d  = 8'($urandom);
        op = 3'($urandom_range(0, 5));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ifa.out_ready = 1'b0;
            ifa.in_valid  = 1'b1;
            ifa.in_data   = d;
            ifa.in_op     = op;
            ifa.in_last   = 1'b1;
            #1;
            if (ifa.in_ready) begin
                eq.push_back(model({4'h0, d}, 2, 3'b000, op));
                acc_n++;
                d  = 8'($urandom);
                op = 3'($urandom_range(0, 5));
            end
            @(posedge clk);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
        #1;
        tests++;
        if (acc_n != 2) begin
            fails++;
            $display("FAIL bp_depth got %0d accepted want 2", acc_n);
        end
        tests++;
        if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full got rdy=%b v=%b want 0/1", ifa.in_ready, ifa.out_valid);
        end
        ifa.out_ready = 1'b1;
        #1;
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_comb got %b want 1", ifa.in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            if (ifa.out_valid) begin
                tests++;
                if (eq.size() == 0) begin
                    fails++;
                    $display("FAIL bp_dup got extra d=%h want none", ifa.out_data);
                end else begin
                    e = eq.pop_front();
                    if (ifa.out_data !== e) begin
                        fails++;
                        $display("FAIL bp_data got %h want %h", ifa.out_data, e);
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        tests++;
        if (eq.size() != 0) begin
            fails++;
            $display("FAIL bp_drain got %0d missing want 0", eq.size());
        end
    endtask

    task automatic test_stream();
        logic [3:0] exp_d[$];
        logic       exp_l[$];
        logic [3:0] e;
        logic       el;
        int         sent = 0;
        int         recv = 0;
        int         budget = 0;
        logic       stalled = 1'b0;
        logic [3:0] held_d = 4'h0;
        logic       held_l = 1'b0;
        logic [7:0] d;
        logic [2:0] op;
        logic       l;
        d  = 8'($urandom);
        op = 3'($urandom);
`ifdef GATE_FOLD_EN
        l = 1'b1;
`else
        l = 1'($urandom);
`endif
        while (recv < 16 && budget < 500) begin
            @(negedge clk);
            ifa.in_valid  = (sent < 16);
            ifa.in_data   = d;
            ifa.in_op     = op;
            ifa.in_last   = l;
            ifa.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                tests++;
                if (ifa.out_valid !== 1'b1 || ifa.out_data !== held_d ||
                    ifa.out_last !== held_l) begin
                    fails++;
                    $display("FAIL stream_hold got v=%b d=%h l=%b want 1/%h/%b",
                             ifa.out_valid, ifa.out_data, ifa.out_last, held_d, held_l);
                end
            end
            stalled = 1'b0;
            if (ifa.out_valid) begin
                if (ifa.out_ready) begin
                    tests++;
                    recv++;
                    if (exp_d.size() == 0) begin
                        fails++;
                        $display("FAIL stream_extra got d=%h want none", ifa.out_data);
                    end else begin
                        e  = exp_d.pop_front();
                        el = exp_l.pop_front();
                        if (ifa.out_data !== e || ifa.out_last !== el) begin
                            fails++;
                            $display("FAIL stream_data got %h/%b want %h/%b",
                                     ifa.out_data, ifa.out_last, e, el);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held_d  = ifa.out_data;
                    held_l  = ifa.out_last;
                end
            end
            if (ifa.in_valid && ifa.in_ready) begin
                exp_d.push_back(model({4'h0, d}, 2, 3'b000, op));
                exp_l.push_back(l);
                sent++;
                d  = 8'($urandom);
                op = 3'($urandom);
`ifndef GATE_FOLD_EN
                l = 1'($urandom);
`endif
            end
            @(posedge clk);
            budget++;
        end
        tests++;
        if (recv != 16 || exp_d.size() != 0) begin
            fails++;
            $display("FAIL stream_count got recv=%0d left=%0d want 16/0", recv, exp_d.size());
        end
        @(negedge clk);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (3) begin
            #1;
            tests++;
            if (ifa.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stream_dup got out_valid=%b want 0", ifa.out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic c_send(input logic [11:0] d, input logic [2:0] op, input logic l);
        int w = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_op    = op;
        ifc.in_last  = l;
        #1;
        while (!ifc.in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        tests++;
        if (ifc.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL c_send_timeout got in_ready=%b want 1", ifc.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic test_fold();
        logic [3:0] e;
        @(negedge clk);
        cq_d.delete(); cq_l.delete(); cq_c.delete();
        e = model(12'h421, 3, 3'b000, 3'd4) ^ model(12'h008, 3, 3'b000, 3'd4)
            ^ model(12'h001, 3, 3'b000, 3'd4);
        c_send(12'h421, 3'd4, 1'b0);
`ifdef GATE_FOLD_EN
        c_send(12'h008, 3'($urandom), 1'b0);
        c_send(12'h001, 3'($urandom), 1'b1);
`else
        c_send(12'h008, 3'd4, 1'b0);
        c_send(12'h001, 3'd4, 1'b1);
`endif
        ifc.in_valid = 1'b0;
        repeat (5) @(negedge clk);
`ifdef GATE_FOLD_EN
        tests++;
        if (cq_d.size() != 1) begin
            fails++;
            $display("FAIL fold_count got %0d outputs want 1", cq_d.size());
        end else begin
            tests++;
            if (cq_d[0] !== e || e !== 4'hE || cq_l[0] !== 1'b1) begin
                fails++;
                $display("FAIL fold_xor got %h/%b want E/1", cq_d[0], cq_l[0]);
            end
            tests++;
            if (cq_c[0] != acc_cyc + 1) begin
                fails++;
                $display("FAIL fold_timing got cyc %0d want %0d", cq_c[0], acc_cyc + 1);
            end
        end
`else
        tests++;
        if (cq_d.size() != 3) begin
            fails++;
            $display("FAIL pass_count got %0d outputs want 3", cq_d.size());
        end else begin
            tests++;
            if (cq_d[0] !== 4'h7 || cq_d[1] !== 4'h8 || cq_d[2] !== 4'h1 ||
                cq_l[0] !== 1'b0 || cq_l[1] !== 1'b0 || cq_l[2] !== 1'b1) begin
                fails++;
                $display("FAIL pass_data got %h%h%h/%b%b%b want 781/001",
                         cq_d[0], cq_d[1], cq_d[2], cq_l[0], cq_l[1], cq_l[2]);
            end
            tests++;
            if (cq_c[2] != acc_cyc + 1) begin
                fails++;
                $display("FAIL pass_timing got cyc %0d want %0d", cq_c[2], acc_cyc + 1);
            end
        end
`endif
    endtask

    task automatic test_fold_reset();
        @(negedge clk);
        cq_d.delete(); cq_l.delete(); cq_c.delete();
        c_send(12'h421, 3'd4, 1'b0);
        c_send(12'h008, 3'd4, 1'b0);
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
`ifdef GATE_FOLD_EN
        tests++;
        if (cq_d.size() != 0) begin
            fails++;
            $display("FAIL fold_reset_emit got %0d outputs want 0", cq_d.size());
        end
`endif
        cq_d.delete(); cq_l.delete(); cq_c.delete();
        c_send(12'h043, 3'd2, 1'b1);
        ifc.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (cq_d.size() != 1) begin
            fails++;
            $display("FAIL reset_or_count got %0d outputs want 1", cq_d.size());
        end else begin
            tests++;
            if (cq_d[0] !== 4'h7 || cq_l[0] !== 1'b1) begin
                fails++;
                $display("FAIL reset_or got %h/%b want 7/1", cq_d[0], cq_l[0]);
            end
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_op = '0;
        ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_op = '0;
        ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_op = '0;
        ifc.in_last = 1'b0; ifc.out_ready = 1'b1;
        test_reset();
        test_latency();
        test_mask();
        test_reserved();
        test_backpressure();
        test_stream();
        test_fold();
        test_fold_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
